// File: rtl/key_move_scheduler.sv
// Debounces the held PS/2 key code, turns each new press into one move command,
// queues moves for the 2048 engine and issues a separate restart pulse.
module key_move_scheduler #(
  parameter int unsigned STABLE_CYCLES = 250000,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic [7:0] xkey,
  input  logic       game_active,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       restart,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES) + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t        state, state_n;
  logic [7:0]    key, key_n;
  logic [CW-1:0] cnt, cnt_n, inc_c;
  logic          press_c, accept_c;
  logic          is_dir_c, is_restart_c;
  logic [1:0]    dir_c;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_n, wr_n;
  logic [NW-1:0] count, count_n;
  logic          push_c, pop_c, flush_c, wr_en_c, ovf_c;
  logic [1:0]    head_dir_c;

  // Key map; the accepted code is always the live xkey.
  always_comb begin
    is_dir_c     = 1'b1;
    is_restart_c = 1'b0;
    dir_c        = 2'b00;
    case (xkey)
      8'h1D, 8'h75: dir_c = 2'b00;
      8'h1B, 8'h72: dir_c = 2'b01;
      8'h1C, 8'h6B: dir_c = 2'b10;
      8'h23, 8'h74: dir_c = 2'b11;
      8'h2D: begin
        is_dir_c     = 1'b0;
        is_restart_c = 1'b1;
      end
      default: is_dir_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      key   <= 8'h00;
      cnt   <= '0;
    end else begin
      state <= state_n;
      key   <= key_n;
      cnt   <= cnt_n;
    end
  end

  // Debounce FSM: a press is accepted once, when the code has been stable long enough.
  always_comb begin
    state_n  = state;
    key_n    = key;
    cnt_n    = cnt;
    press_c  = 1'b0;
    accept_c = 1'b0;
    inc_c    = cnt + CW'(1);
    case (state)
      IDLE: press_c = (xkey != 8'h00);
      SETTLE: begin
        if (xkey == 8'h00) begin
          state_n = IDLE;
        end else if (xkey != key) begin
          press_c = 1'b1;
        end else begin
          cnt_n = inc_c;
          if (inc_c == LAST) begin
            accept_c = 1'b1;
            state_n  = HELD;
          end
        end
      end
      HELD: begin
        if (xkey == 8'h00) state_n = IDLE;
        else if (xkey != key) press_c = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (press_c) begin
      key_n = xkey;
      cnt_n = '0;
      if (STABLE_CYCLES == 1) begin
        accept_c = 1'b1;
        state_n  = HELD;
      end else begin
        state_n = SETTLE;
      end
    end
  end

  assign push_c  = accept_c && is_dir_c && game_active;
  assign flush_c = accept_c && is_restart_c;
  assign pop_c   = move_valid && move_ready;

  // Queue bookkeeping; flush wins over a same-cycle pop.
  always_comb begin
    rd_n    = rd_ptr;
    wr_n    = wr_ptr;
    count_n = count;
    wr_en_c = 1'b0;
    ovf_c   = 1'b0;
    if (flush_c) begin
      rd_n    = '0;
      wr_n    = '0;
      count_n = '0;
    end else begin
      if (pop_c) rd_n = rd_ptr + AW'(1);
      if (push_c) begin
        if (count == FULL && !pop_c) begin
          ovf_c = 1'b1;
        end else begin
          wr_en_c = 1'b1;
          wr_n    = wr_ptr + AW'(1);
        end
      end
      count_n = count + NW'(wr_en_c) - NW'(pop_c);
    end
    head_dir_c = (wr_en_c && rd_n == wr_ptr) ? dir_c : mem[rd_n];
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= 2'b00;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      move_valid <= 1'b0;
      move_dir   <= 2'b00;
      fifo_full  <= 1'b0;
      restart    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en_c) mem[wr_ptr] <= dir_c;
      rd_ptr     <= rd_n;
      wr_ptr     <= wr_n;
      count      <= count_n;
      move_valid <= (count_n != '0);
      fifo_full  <= (count_n == FULL);
      if (count_n != '0) move_dir <= head_dir_c;
      restart    <= flush_c;
      overflow   <= ovf_c;
    end
  end

endmodule

// File: tb/tb_key_move_scheduler.sv
// Bench for key_move_scheduler: directed scenarios plus random key runs,
// checked every cycle against a press-run / queue reference model.
module tb_key_move_scheduler;

  localparam int unsigned S = 4;
  localparam int unsigned D = 4;

  logic       clk25 = 1'b0;
  logic       rst;
  logic [7:0] xkey;
  logic       game_active;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       restart;
  logic       fifo_full;
  logic       overflow;

  key_move_scheduler #(.STABLE_CYCLES(S), .FIFO_DEPTH(D)) dut (
    .clk25(clk25), .rst(rst), .xkey(xkey), .game_active(game_active),
    .move_ready(move_ready), .move_valid(move_valid), .move_dir(move_dir),
    .restart(restart), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #20 clk25 = ~clk25;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a press is a run of one nonzero code; it fires when the run reaches S cycles.
  logic [1:0] q[$];
  logic [7:0] prev;
  int         runlen;
  logic [1:0] dir_hold;
  logic       exp_restart, exp_ovf;

  function automatic int dir_of(input logic [7:0] k);
    case (k)
      8'h1D, 8'h75: return 0;
      8'h1B, 8'h72: return 1;
      8'h1C, 8'h6B: return 2;
      8'h23, 8'h74: return 3;
      default:      return -1;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    prev        = 8'h00;
    runlen      = 0;
    dir_hold    = 2'b00;
    exp_restart = 1'b0;
    exp_ovf     = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    bit pop;
    int d;
    pop = (q.size() != 0) && move_ready;
    acc = 1'b0;
    if (xkey == 8'h00) begin
      runlen = 0;
    end else begin
      if (xkey != prev) runlen = 1;
      else runlen++;
      acc = (runlen == int'(S));
    end
    prev        = xkey;
    exp_restart = 1'b0;
    exp_ovf     = 1'b0;
    d           = dir_of(xkey);
    if (acc && xkey == 8'h2D) begin
      q.delete();
      exp_restart = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc && d >= 0 && game_active) begin
        if (q.size() == int'(D)) exp_ovf = 1'b1;
        else q.push_back(2'(d));
      end
    end
    if (q.size() != 0) dir_hold = q[0];
  endtask

  task automatic check_outputs(input string ph);
    check({ph, ".move_valid"}, 8'(move_valid), 8'(q.size() != 0));
    check({ph, ".move_dir"},   8'(move_dir),   8'(dir_hold));
    check({ph, ".fifo_full"},  8'(fifo_full),  8'(q.size() == int'(D)));
    check({ph, ".restart"},    8'(restart),    8'(exp_restart));
    check({ph, ".overflow"},   8'(overflow),   8'(exp_ovf));
  endtask

  task automatic cycle(input string ph, input logic [7:0] k, input logic ga, input logic rdy);
    xkey        = k;
    game_active = ga;
    move_ready  = rdy;
    @(posedge clk25);
    model_step();
    #1;
    check_outputs(ph);
  endtask

  task automatic hold(input string ph, input logic [7:0] k, input int n,
                      input logic ga = 1'b1, input logic rdy = 1'b0);
    for (int i = 0; i < n; i++) cycle(ph, k, ga, rdy);
  endtask

  logic [7:0] codes [12] = '{8'h00, 8'h1D, 8'h75, 8'h1B, 8'h72, 8'h1C,
                              8'h6B, 8'h23, 8'h74, 8'h2D, 8'h12, 8'h00};

  initial begin
    rst         = 1'b1;
    xkey        = 8'h00;
    game_active = 1'b1;
    move_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk25);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    hold("basic", 8'h1D, 4);
    hold("basic", 8'h00, 2);
    hold("basic", 8'h00, 1, 1'b1, 1'b1);
    hold("basic", 8'h00, 2);

    hold("glitch", 8'h74, 3);
    hold("glitch", 8'h00, 2);
    hold("repeat", 8'h74, 100);
    hold("repeat", 8'h00, 2);
    hold("repeat", 8'h00, 3, 1'b1, 1'b1);

    foreach (codes[i]) if (i >= 1 && i <= 5) begin
      hold("ovf", (i == 5) ? 8'h1D : ((i == 1) ? 8'h75 : (i == 2) ? 8'h72 : (i == 3) ? 8'h6B : 8'h74), 4);
      hold("ovf", 8'h00, 1);
    end
    hold("drain", 8'h00, 6, 1'b1, 1'b1);

    hold("flush", 8'h1D, 4);
    hold("flush", 8'h00, 1);
    hold("flush", 8'h1B, 4);
    hold("flush", 8'h00, 1);
    hold("flush", 8'h2D, 4);
    hold("flush", 8'h00, 3);

    hold("roll", 8'h1C, 4);
    hold("roll", 8'h23, 4);
    hold("roll", 8'h00, 2);
    hold("roll", 8'h00, 3, 1'b1, 1'b1);
    hold("gate", 8'h1C, 4, 1'b0);
    hold("gate", 8'h23, 4, 1'b0);
    hold("gate", 8'h2D, 4, 1'b0);
    hold("gate", 8'h00, 2, 1'b0);

    hold("fullpop", 8'h75, 4); hold("fullpop", 8'h00, 1);
    hold("fullpop", 8'h72, 4); hold("fullpop", 8'h00, 1);
    hold("fullpop", 8'h6B, 4); hold("fullpop", 8'h00, 1);
    hold("fullpop", 8'h74, 4); hold("fullpop", 8'h00, 1);
    hold("fullpop", 8'h1D, 3);
    cycle("fullpop", 8'h1D, 1'b1, 1'b1);
    hold("fullpop", 8'h00, 2);
    hold("fullpop", 8'h00, 6, 1'b1, 1'b1);

    hold("arst", 8'h72, 4);
    hold("arst", 8'h00, 1);
    hold("arst", 8'h1C, 2);
    rst = 1'b1;
    #5;
    check("arst.move_valid", 8'(move_valid), 8'h00);
    check("arst.move_dir",   8'(move_dir),   8'h00);
    check("arst.fifo_full",  8'(fifo_full),  8'h00);
    check("arst.restart",    8'(restart),    8'h00);
    check("arst.overflow",   8'(overflow),   8'h00);
    model_reset();
    @(posedge clk25);
    #1;
    rst = 1'b0;
    hold("arst", 8'h1C, 4);
    hold("arst", 8'h00, 2);
    hold("arst", 8'h00, 3, 1'b1, 1'b1);

    for (int seg = 0; seg < 400; seg++) begin
      logic [7:0] k;
      int         len;
      logic       ga;
      k   = codes[$urandom_range(0, 11)];
      len = int'($urandom_range(1, 7));
      ga  = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < len; c++) cycle("rand", k, ga, 1'($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
